fifo_burst_arbiter: RTL and testbench
=====================================

# fifo_burst_arbiter

Parametrised N-channel burst read arbiter for the upload path. It sits between the read ports of the per-channel dual-clock capture FIFOs, all in the `fifo_rdclk` domain, and the upload stage. Arbitration is round-robin. When a channel holds at least one full burst and the upload side is ready, the block drains exactly `BURST_LEN` words from that channel. It can prefix each burst with a framing header and marks the first and last words of every frame.

## Interface
- `CH_NUM`, 4: number of channels, 2..16.
- `DATA_W`, 64: FIFO read and upload word width; must be ≥ 64.
- `USEDW_W`, 13: width of each FIFO `rdusedw`.
- `BURST_LEN`, 128: words per burst, 1..2^USEDW_W−1.
- `GAP_CYC`, 2: idle cycles after each burst so `rdusedw` settles; ≥ 2.
- `HEADER_EN`, 1: 1 = emit a header word before each burst.
- `HEADER_TAG`, 16'hA55A: header sync tag.

Ports:
- `fifo_rdclk`  in  1: the only clock.
- `rst`  in  1: synchronous, active-high reset.
- `ch_rdusedw`  in  CH_NUM*USEDW_W: per-channel read fill level; channel i occupies slice [i*USEDW_W +: USEDW_W].
- `ch_q`  in  CH_NUM*DATA_W: per-channel FIFO read data, non-showahead. Data is valid the cycle after `rdreq`.
- `ch_rdreq`  out  CH_NUM: per-channel read request; at most one bit is set at a time.
- `up_ready`  in  1: upload side can accept a frame. Sampled only when a burst is granted.
- `data_valid`  out  1: `up_data` is valid.
- `up_data`  out  DATA_W: upload word.
- `up_sop`  out  1: first word of a frame.
- `up_eop`  out  1: last word of a frame.
- `cur_ch`  out  4: index of the granted channel. Held through the burst and until the next grant.

## Operation
- FSM states: IDLE, RD, DRAIN.
- Channel i is eligible when `rdusedw_i ≥ BURST_LEN`. This is a comparison, not an equality test.
- **IDLE:**
  - Search eligible channels starting at `ptr+1` and wrapping modulo `CH_NUM`. The first hit wins.
  - If there is a hit and `up_ready` = 1: register `cur_ch`, load the beat counter to 0, and go to RD.
  - Otherwise stay in IDLE.
- **RD:**
  - `ch_rdreq[cur_ch]` = 1 on every RD cycle. The beat counter increments each cycle.
  - After `BURST_LEN` cycles, go to DRAIN.
  - `up_ready` is ignored inside a burst. There is no mid-burst stall.
- **DRAIN:** hold for `GAP_CYC` cycles, then go to IDLE and set `ptr` ← `cur_ch`.
- **Output pipeline:** `ch_q[cur_ch]` is registered to `up_data` one cycle after it becomes valid.
- **Header** (`HEADER_EN` = 1): one word, issued the cycle before the first data word.
  - Bits [63:48] = `HEADER_TAG`.
  - Bits [47:40] = `cur_ch`.
  - Bits [39:24] = `BURST_LEN`.
  - Bits [23:0] = `frame_seq`.
  - Bits above 63 are zero.
- **frame_seq:** 24-bit global counter. It increments once per granted burst, after that burst's header has been issued, and wraps from 0xFFFFFF to 0.
- **SOP/EOP:**
  - `up_sop` is set on the header word, or on the first data word when `HEADER_EN` = 0.
  - `up_eop` is set on data word `BURST_LEN`.
  - With `BURST_LEN` = 1 and `HEADER_EN` = 0, `up_sop` and `up_eop` are both set on the single word.
- **Simultaneous eligibility:** round-robin order decides; fixed priority is never used. A channel that stays full can be granted again only after every other eligible channel has been served.
- **Reset, including mid-burst:**
  - On the next edge, the FSM returns to IDLE and all `ch_rdreq` drop.
  - `data_valid`, `up_sop` and `up_eop` go to 0.
  - `up_data`, `cur_ch`, `frame_seq` and the beat counter go to 0.
  - `ptr` goes to `CH_NUM−1`, so channel 0 has first priority.
  - A partial frame is abandoned with no EOP.

## Timing
- T = the IDLE cycle in which a grant condition is sampled true.
- `ch_rdreq[g]` is high on cycles T+1 .. T+BURST_LEN.
- FIFO `q` is valid on cycles T+2 .. T+BURST_LEN+1.
- Header: `data_valid` = 1 with the header word at T+2.
- Data words: `data_valid` = 1 at T+3 .. T+BURST_LEN+2. Output is contiguous, with no holes.
- With `HEADER_EN` = 0, the output window is the same, but no word is emitted at T+2.
- DRAIN occupies T+BURST_LEN+1 .. T+BURST_LEN+GAP_CYC. The earliest next grant evaluation is T+BURST_LEN+GAP_CYC+1.
- With the defaults, the frame period is 131 cycles: 128 RD + 2 DRAIN + 1 IDLE.
- All outputs are registered. No combinational path exists from inputs to outputs.

## Test plan
- **Single burst.** Set ch2 `rdusedw` to 200, all others to 0, `up_ready` = 1. Expect:
  - `ch_rdreq` = 4'b0100 for exactly 128 cycles.
  - The header is 0xA55A_02_0080_000000, with SOP.
  - 128 data words follow, in FIFO order, with EOP on the last.
- **All channels eligible.** Hold every `rdusedw` at 4000. Expect:
  - Grants in the order ch0, ch1, ch2, ch3, ch0.
  - `frame_seq` in the headers = 0, 1, 2, 3, 4.
  - Consecutive header starts 131 cycles apart.
- **Threshold boundary.**
  - `rdusedw` = 127: no grant.
  - `rdusedw` = 128: grant in the following cycle.
  - `rdusedw` = 129: grant as well, confirming a ≥ comparison.
- **Backpressure.** Hold `up_ready` = 0 while ch1 is eligible: no `rdreq`. Raise `up_ready` at cycle N: `rdreq` rises at N+1. Dropping `up_ready` mid-burst changes nothing.
- **Reset mid-burst.** Assert `rst` at beat 50. Expect:
  - Next cycle: `rdreq` = 0, `data_valid` = 0, no EOP.
  - After release, ch0 is the first channel served and the header `seq` = 0.
- **Sequence wrap.** Preload `frame_seq` to 0xFFFFFF via force. Expect headers showing 0xFFFFFF, then 0x000000.

Source files
------------

// File: rtl/fifo_burst_arbiter_if.sv
// Handshake bundle between the capture FIFO read ports, the burst arbiter and the upload stage.
interface fifo_burst_arbiter_if #(
  parameter int CH_NUM  = 4,
  parameter int DATA_W  = 64,
  parameter int USEDW_W = 13
);
  logic [CH_NUM*USEDW_W-1:0] ch_rdusedw;
  logic [CH_NUM*DATA_W-1:0]  ch_q;
  logic [CH_NUM-1:0]         ch_rdreq;
  logic                      up_ready;
  logic                      data_valid;
  logic [DATA_W-1:0]         up_data;
  logic                      up_sop;
  logic                      up_eop;
  logic [3:0]                cur_ch;

  modport master (
    input  ch_rdusedw, ch_q, up_ready,
    output ch_rdreq, data_valid, up_data, up_sop, up_eop, cur_ch
  );

  modport slave (
    output ch_rdusedw, ch_q, up_ready,
    input  ch_rdreq, data_valid, up_data, up_sop, up_eop, cur_ch
  );
endinterface

// File: rtl/fifo_burst_arbiter.sv
// Round-robin burst read arbiter: drains BURST_LEN words from one full channel per grant,
// optionally prefixed by a framing header, with SOP/EOP marking on the upload side.
//   state | meaning
//   IDLE  | searching for an eligible channel while upload is ready
//   RD    | issuing BURST_LEN back-to-back reads from cur_ch
//   DRAIN | GAP_CYC idle cycles so rdusedw settles before next search
module fifo_burst_arbiter #(
  parameter int          CH_NUM     = 4,
  parameter int          DATA_W     = 64,
  parameter int          USEDW_W    = 13,
  parameter int          BURST_LEN  = 128,
  parameter int          GAP_CYC    = 2,
  parameter int          HEADER_EN  = 1,
  parameter logic [15:0] HEADER_TAG = 16'hA55A
) (
  input  logic           fifo_rdclk,
  input  logic           rst,
  fifo_burst_arbiter_if.master bus
);
  localparam int BEAT_W = $clog2(BURST_LEN + GAP_CYC + 1);
  localparam logic [BEAT_W-1:0]  LAST_RD    = BEAT_W'(BURST_LEN - 1);
  localparam logic [BEAT_W-1:0]  LAST_GAP   = BEAT_W'(BURST_LEN + GAP_CYC - 1);
  localparam logic [BEAT_W-1:0]  FIRST_DATA = BEAT_W'(1);
  localparam logic [BEAT_W-1:0]  LAST_DATA  = BEAT_W'(BURST_LEN);
  localparam logic [USEDW_W-1:0] THRESH     = USEDW_W'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, RD, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [3:0]          cur_ch_q, cur_ch_d;
  logic [3:0]          ptr_q, ptr_d;
  logic [23:0]         seq_q, seq_d;
  logic [CH_NUM-1:0]   rdreq_q, rdreq_d;
  logic                rd_valid_q;
  logic                valid_q, valid_d;
  logic                sop_q, sop_d;
  logic                eop_q, eop_d;
  logic [DATA_W-1:0]   up_data_q, up_data_d;
  logic                hit;
  logic [3:0]          hit_ch;
  logic [4:0]          cand;
  logic [DATA_W-1:0]   hdr;

  always_ff @(posedge fifo_rdclk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      cur_ch_q   <= '0;
      ptr_q      <= 4'(CH_NUM - 1);
      seq_q      <= '0;
      rdreq_q    <= '0;
      rd_valid_q <= 1'b0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      up_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      cur_ch_q   <= cur_ch_d;
      ptr_q      <= ptr_d;
      seq_q      <= seq_d;
      rdreq_q    <= rdreq_d;
      rd_valid_q <= |rdreq_q;
      valid_q    <= valid_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      up_data_q  <= up_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    cur_ch_d  = cur_ch_q;
    ptr_d     = ptr_q;
    seq_d     = seq_q;
    up_data_d = up_data_q;
    valid_d   = 1'b0;
    sop_d     = 1'b0;
    eop_d     = 1'b0;
    rdreq_d   = '0;
    hit       = 1'b0;
    hit_ch    = '0;
    cand      = '0;
    hdr       = '0;

    // search starts one past the last served channel and wraps
    for (int i = 1; i <= CH_NUM; i++) begin
      cand = {1'b0, ptr_q} + 5'(i);
      if (cand >= 5'(CH_NUM)) cand = cand - 5'(CH_NUM);
      if (!hit && (bus.ch_rdusedw[cand[3:0]*USEDW_W +: USEDW_W] >= THRESH)) begin
        hit    = 1'b1;
        hit_ch = cand[3:0];
      end
    end

    hdr[63:48] = HEADER_TAG;
    hdr[47:40] = {4'b0, cur_ch_q};
    hdr[39:24] = 16'(BURST_LEN);
    hdr[23:0]  = seq_q;

    case (state_q)
      IDLE: begin
        if (hit && bus.up_ready) begin
          state_d  = RD;
          cur_ch_d = hit_ch;
          beat_d   = '0;
        end
      end
      RD: begin
        beat_d = beat_q + 1'b1;
        if (beat_q == '0) begin
          seq_d = seq_q + 1'b1;
          if (HEADER_EN != 0) begin
            up_data_d = hdr;
            valid_d   = 1'b1;
            sop_d     = 1'b1;
          end
        end
        if (beat_q == LAST_RD) state_d = DRAIN;
      end
      DRAIN: begin
        beat_d = beat_q + 1'b1;
        if (beat_q == LAST_GAP) begin
          state_d = IDLE;
          ptr_d   = cur_ch_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // beat_q equals the data word number while FIFO q is valid
    if (rd_valid_q) begin
      up_data_d = bus.ch_q[cur_ch_q*DATA_W +: DATA_W];
      valid_d   = 1'b1;
      sop_d     = (HEADER_EN == 0) && (beat_q == FIRST_DATA);
      eop_d     = (beat_q == LAST_DATA);
    end

    for (int c = 0; c < CH_NUM; c++) begin
      rdreq_d[c] = (state_d == RD) && (cur_ch_d == 4'(c));
    end
  end

  assign bus.ch_rdreq   = rdreq_q;
  assign bus.data_valid = valid_q;
  assign bus.up_data    = up_data_q;
  assign bus.up_sop     = sop_q;
  assign bus.up_eop     = eop_q;
  assign bus.cur_ch     = cur_ch_q;
endmodule

// File: tb/tb_fifo_burst_arbiter.sv
// Self-checking bench for fifo_burst_arbiter: FIFO model, output monitor and a round-robin frame model.
module tb_fifo_burst_arbiter;
  localparam int CH    = 4;
  localparam int DW    = 64;
  localparam int UW    = 13;
  localparam int BL    = 128;
  localparam int GAP   = 2;
  localparam int FRAME = BL + 1;
  localparam int PERIOD = BL + GAP + 1;

  typedef struct { logic [63:0] d; logic sop; logic eop; int cyc; } word_t;
  typedef struct { int ch; int base; int cyc; } grant_t;

  logic clk = 1'b0;
  logic rst;
  logic up_ready_r;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [UW-1:0] usedw [CH];
  logic [DW-1:0] q_r [CH] = '{default: '0};
  int   pop_cnt [CH] = '{default: 0};
  int   rdreq_cnt [CH];
  int   onehot_err;
  bit   rdreq_prev = 1'b0;
  int   mon_c;
  logic [31:0] salt;
  word_t  outq[$];
  grant_t grants[$];
  int   model_ptr;
  int   model_seq;

  fifo_burst_arbiter_if #(.CH_NUM(CH), .DATA_W(DW), .USEDW_W(UW)) bus();

  fifo_burst_arbiter #(
    .CH_NUM(CH), .DATA_W(DW), .USEDW_W(UW), .BURST_LEN(BL), .GAP_CYC(GAP),
    .HEADER_EN(1), .HEADER_TAG(16'hA55A)
  ) dut (
    .fifo_rdclk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    assign bus.ch_rdusedw[g*UW +: UW] = usedw[g];
    assign bus.ch_q[g*DW +: DW]       = q_r[g];
  end
  assign bus.up_ready = up_ready_r;

  function automatic logic [63:0] fifo_word(int ch, int n);
    return {salt, 8'(ch), 24'(n)};
  endfunction

  function automatic logic [63:0] hdr(int ch, int seq);
    return {16'hA55A, 8'(ch), 16'(BL), 24'(seq)};
  endfunction

  // non-showahead FIFO: word appears the cycle after rdreq
  always @(posedge clk) begin
    for (int i = 0; i < CH; i++) begin
      if (bus.ch_rdreq[i] === 1'b1) begin
        q_r[i]     <= fifo_word(i, pop_cnt[i]);
        pop_cnt[i] <= pop_cnt[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.data_valid === 1'b1)
      outq.push_back('{d: bus.up_data, sop: bus.up_sop, eop: bus.up_eop, cyc: cyc});
    if ((|bus.ch_rdreq) === 1'b1 && !rdreq_prev) begin
      mon_c = 0;
      for (int i = 0; i < CH; i++) if (bus.ch_rdreq[i] === 1'b1) mon_c = i;
      grants.push_back('{ch: mon_c, base: pop_cnt[mon_c], cyc: cyc});
    end
    rdreq_prev = ((|bus.ch_rdreq) === 1'b1);
    for (int i = 0; i < CH; i++) if (bus.ch_rdreq[i] === 1'b1) rdreq_cnt[i]++;
    if ($countones(bus.ch_rdreq) > 1) onehot_err++;
  end

  // spec rule: first eligible channel after the last served one, modulo CH
  function automatic int rr_pick(int ptr, logic [CH-1:0] elig);
    for (int k = 1; k <= CH; k++) if (elig[(ptr + k) % CH]) return (ptr + k) % CH;
    return -1;
  endfunction

  // mismatching words of the frame at outq[idx]: header, FIFO-ordered data, flags, timing
  function automatic int frame_errs(int idx, int ch, int seq, int base, int rise);
    int e = 0;
    if (outq.size() < idx + FRAME) return FRAME;
    if (outq[idx].d !== hdr(ch, seq) || outq[idx].sop !== 1'b1 || outq[idx].eop !== 1'b0 ||
        outq[idx].cyc != rise + 1) e++;
    for (int k = 1; k <= BL; k++) begin
      word_t w = outq[idx + k];
      if (w.d !== fifo_word(ch, base + k - 1) || w.sop !== 1'b0 || w.eop !== (k == BL) ||
          w.cyc != rise + 1 + k) e++;
    end
    return e;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_grants(int n, int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (grants.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_words(int n, int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (outq.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    up_ready_r = 1'b1;
    for (int i = 0; i < CH; i++) usedw[i] = '0;
    tick();
    tick();
    rst = 1'b0;
    outq.delete();
    grants.delete();
    for (int i = 0; i < CH; i++) rdreq_cnt[i] = 0;
    onehot_err = 0;
    model_ptr = CH - 1;
    model_seq = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.ch_rdreq !== '0) begin errors++; $display("FAIL reset_rdreq got %b want 0", bus.ch_rdreq); end
    checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.data_valid); end
    checks++; if (bus.up_sop !== 1'b0) begin errors++; $display("FAIL reset_sop got %b want 0", bus.up_sop); end
    checks++; if (bus.up_eop !== 1'b0) begin errors++; $display("FAIL reset_eop got %b want 0", bus.up_eop); end
    checks++; if (bus.up_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", bus.up_data); end
    checks++; if (bus.cur_ch !== 4'd0) begin errors++; $display("FAIL reset_cur_ch got %0d want 0", bus.cur_ch); end
    rst = 1'b0;
  endtask

  task automatic test_single_burst();
    bit ok;
    int e, others;
    do_reset();
    for (int i = 0; i < CH; i++) usedw[i] = UW'($urandom_range(0, BL - 1));
    usedw[2] = 13'd200;
    wait_grants(1, 20, ok);
    usedw[2] = '0;
    checks++; if (!ok) begin errors++; $display("FAIL single_grant timeout got 0 grants want 1"); end
    wait_words(FRAME, 300, ok);
    tick();
    checks++; if (!ok) begin errors++; $display("FAIL single_words got %0d want %0d", outq.size(), FRAME); end
    if (ok) begin
      checks++; if (grants[0].ch != rr_pick(model_ptr, 4'b0100)) begin errors++; $display("FAIL single_ch got %0d want 2", grants[0].ch); end
      checks++; if (outq[0].d !== hdr(2, 0)) begin errors++; $display("FAIL single_header got %h want %h", outq[0].d, hdr(2, 0)); end
      e = frame_errs(0, 2, 0, grants[0].base, grants[0].cyc);
      checks++; if (e != 0) begin errors++; $display("FAIL single_frame got %0d bad words want 0", e); end
    end
    others = rdreq_cnt[0] + rdreq_cnt[1] + rdreq_cnt[3];
    checks++; if (rdreq_cnt[2] != BL || others != 0) begin errors++; $display("FAIL single_rdreq got ch2=%0d others=%0d want %0d/0", rdreq_cnt[2], others, BL); end
    checks++; if (bus.cur_ch !== 4'd2) begin errors++; $display("FAIL single_cur_ch got %0d want 2", bus.cur_ch); end
    repeat (20) tick();
    checks++; if (outq.size() != FRAME) begin errors++; $display("FAIL single_extra got %0d words want %0d", outq.size(), FRAME); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int e, exp_ch;
    do_reset();
    for (int i = 0; i < CH; i++) usedw[i] = UW'($urandom_range(BL, 8191));
    wait_grants(5, 5 * PERIOD + 20, ok);
    for (int i = 0; i < CH; i++) usedw[i] = '0;
    checks++; if (!ok) begin errors++; $display("FAIL rr_grants got %0d want 5", grants.size()); end
    wait_words(5 * FRAME, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_words got %0d want %0d", outq.size(), 5 * FRAME); end
    if (ok) begin
      for (int f = 0; f < 5; f++) begin
        exp_ch = rr_pick(model_ptr, 4'b1111);
        checks++; if (grants[f].ch != exp_ch) begin errors++; $display("FAIL rr_order[%0d] got %0d want %0d", f, grants[f].ch, exp_ch); end
        e = frame_errs(f * FRAME, exp_ch, model_seq, grants[f].base, grants[f].cyc);
        checks++; if (e != 0) begin errors++; $display("FAIL rr_frame[%0d] got %0d bad words want 0", f, e); end
        if (f > 0) begin
          checks++;
          if (outq[f * FRAME].cyc - outq[(f - 1) * FRAME].cyc != PERIOD) begin
            errors++;
            $display("FAIL rr_period[%0d] got %0d want %0d", f, outq[f * FRAME].cyc - outq[(f - 1) * FRAME].cyc, PERIOD);
          end
        end
        model_ptr = exp_ch;
        model_seq = (model_seq + 1) % (1 << 24);
      end
    end
    checks++; if (onehot_err != 0) begin errors++; $display("FAIL rr_onehot got %0d violations want 0", onehot_err); end
  endtask

  task automatic test_threshold();
    bit ok;
    int set_c, e;
    do_reset();
    usedw[1] = 13'd127;
    repeat (20) tick();
    checks++; if (grants.size() != 0) begin errors++; $display("FAIL thr_127 got %0d grants want 0", grants.size()); end
    set_c = cyc;
    usedw[1] = 13'd128;
    wait_grants(1, 10, ok);
    usedw[1] = '0;
    checks++; if (!ok || grants[0].cyc != set_c + 1 || grants[0].ch != 1) begin
      errors++; $display("FAIL thr_128 got ok=%0d cyc=%0d want cyc=%0d ch1", ok, ok ? grants[0].cyc : -1, set_c + 1);
    end
    wait_words(FRAME, 300, ok);
    if (ok) begin
      e = frame_errs(0, 1, 0, grants[0].base, grants[0].cyc);
      checks++; if (e != 0) begin errors++; $display("FAIL thr_frame128 got %0d bad words want 0", e); end
    end
    repeat (5) tick();
    set_c = cyc;
    usedw[3] = 13'd129;
    wait_grants(2, 10, ok);
    usedw[3] = '0;
    checks++; if (!ok || grants[1].cyc != set_c + 1 || grants[1].ch != rr_pick(1, 4'b1000)) begin
      errors++; $display("FAIL thr_129 got ok=%0d cyc=%0d want cyc=%0d ch3", ok, ok ? grants[1].cyc : -1, set_c + 1);
    end
    wait_words(2 * FRAME, 300, ok);
    if (ok) begin
      e = frame_errs(FRAME, 3, 1, grants[1].base, grants[1].cyc);
      checks++; if (e != 0) begin errors++; $display("FAIL thr_frame129 got %0d bad words want 0", e); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int set_c, e;
    do_reset();
    up_ready_r = 1'b0;
    usedw[1] = UW'($urandom_range(BL, 8191));
    repeat (30) tick();
    checks++; if (grants.size() != 0 || rdreq_cnt[1] != 0) begin errors++; $display("FAIL bp_hold got %0d grants want 0", grants.size()); end
    set_c = cyc;
    up_ready_r = 1'b1;
    wait_grants(1, 10, ok);
    usedw[1] = '0;
    checks++; if (!ok || grants[0].cyc != set_c + 1) begin
      errors++; $display("FAIL bp_rise got ok=%0d cyc=%0d want %0d", ok, ok ? grants[0].cyc : -1, set_c + 1);
    end
    repeat (40) tick();
    up_ready_r = 1'b0;
    wait_words(FRAME, 300, ok);
    if (ok) begin
      e = frame_errs(0, 1, 0, grants[0].base, grants[0].cyc);
      checks++; if (e != 0) begin errors++; $display("FAIL bp_frame got %0d bad words want 0", e); end
    end
    checks++; if (rdreq_cnt[1] != BL) begin errors++; $display("FAIL bp_rdreq got %0d want %0d", rdreq_cnt[1], BL); end
    up_ready_r = 1'b1;
  endtask

  task automatic test_reset_midburst();
    bit ok;
    int n_before, eops, e;
    do_reset();
    usedw[3] = 13'd300;
    wait_grants(1, 20, ok);
    usedw[3] = '0;
    repeat (50) tick();
    rst = 1'b1;
    for (int i = 0; i < CH; i++) usedw[i] = 13'd4000;
    tick();
    checks++; if (bus.ch_rdreq !== '0) begin errors++; $display("FAIL rstmid_rdreq got %b want 0", bus.ch_rdreq); end
    checks++; if (bus.data_valid !== 1'b0 || bus.up_eop !== 1'b0) begin
      errors++; $display("FAIL rstmid_valid got valid=%b eop=%b want 0/0", bus.data_valid, bus.up_eop);
    end
    eops = 0;
    foreach (outq[i]) if (outq[i].eop) eops++;
    checks++; if (eops != 0) begin errors++; $display("FAIL rstmid_no_eop got %0d eops want 0", eops); end
    n_before = outq.size();
    rst = 1'b0;
    model_ptr = CH - 1;
    model_seq = 0;
    wait_grants(2, 20, ok);
    for (int i = 0; i < CH; i++) usedw[i] = '0;
    checks++; if (!ok || grants[1].ch != rr_pick(model_ptr, 4'b1111)) begin
      errors++; $display("FAIL rstmid_first got ch=%0d want 0", ok ? grants[1].ch : -1);
    end
    wait_words(n_before + FRAME, 300, ok);
    if (ok) begin
      e = frame_errs(n_before, 0, 0, grants[1].base, grants[1].cyc);
      checks++; if (e != 0) begin errors++; $display("FAIL rstmid_frame got %0d bad words want 0", e); end
    end
  endtask

  task automatic test_seq_wrap();
    bit ok;
    int e;
    do_reset();
    force dut.seq_q = 24'hFFFFFF;
    tick();
    release dut.seq_q;
    model_seq = 24'hFFFFFF;
    usedw[0] = 13'd300;
    usedw[1] = 13'd300;
    wait_grants(2, 2 * PERIOD + 20, ok);
    usedw[0] = '0;
    usedw[1] = '0;
    wait_words(2 * FRAME, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_words got %0d want %0d", outq.size(), 2 * FRAME); end
    if (ok) begin
      checks++; if (outq[0].d[23:0] !== 24'hFFFFFF) begin errors++; $display("FAIL wrap_seq0 got %h want ffffff", outq[0].d[23:0]); end
      checks++; if (outq[FRAME].d[23:0] !== 24'h000000) begin errors++; $display("FAIL wrap_seq1 got %h want 000000", outq[FRAME].d[23:0]); end
      e = frame_errs(0, 0, model_seq, grants[0].base, grants[0].cyc);
      model_seq = (model_seq + 1) % (1 << 24);
      e += frame_errs(FRAME, 1, model_seq, grants[1].base, grants[1].cyc);
      checks++; if (e != 0) begin errors++; $display("FAIL wrap_frames got %0d bad words want 0", e); end
    end
  endtask

  initial begin
    salt = $urandom;
    rst = 1'b1;
    up_ready_r = 1'b1;
    for (int i = 0; i < CH; i++) usedw[i] = '0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_threshold();
    test_backpressure();
    test_reset_midburst();
    test_seq_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
